// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer arbiter: controller state encodings,
// the default word width, and the rotating first-set-bit search used by the
// requester arbiter.
package spi_pkg;

    localparam int DEF_DATA_WIDTH = 16;

    // Controller states
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] XFER  = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    // Index of the first set bit of vec[n-1:0], scanning upward from ptr and
    // wrapping past n-1 back to 0. Returns -1 when no bit is set. Requester
    // vectors are at most 8 wide, so callers zero-pad into 8 bits.
    function automatic int first_set_from(input logic [7:0] vec, input int ptr, input int n);
        int idx;
        first_set_from = -1;
        for (int k = 0; k < 8; k++) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (vec[idx[2:0]] && first_set_from < 0) first_set_from = idx;
            end
        end
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational requester arbiter: request vector plus rotation pointer in,
// one-hot grant and its index out.
// Build option SPI_XFER_ARB_PRIORITY_EN: fixed priority, lowest index wins,
// and the pointer input is not used.
module spi_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               any
);
    import spi_pkg::*;

    logic [7:0] req_pad;
    int         pick;

    // Pick the winning requester and encode it both one-hot and as an index
    always_comb begin
        req_pad = '0;
        req_pad[NUM_REQ-1:0] = req;
`ifdef SPI_XFER_ARB_PRIORITY_EN
        pick = first_set_from(req_pad, 0, NUM_REQ);
`else
        pick = first_set_from(req_pad, int'(ptr), NUM_REQ);
`endif
        grant     = '0;
        grant_idx = '0;
        any       = (pick >= 0);
        if (pick >= 0) begin
            grant[pick[PTR_W-1:0]] = 1'b1;
            grant_idx              = pick[PTR_W-1:0];
        end
    end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one SPI shift engine among NUM_REQ requesters. Each transfer runs
// IDLE (arbitrate) -> SETUP (slave selected, engine idle) -> XFER (wait for
// engine) -> GAP (GAP_CYCLES with no slave selected) -> IDLE.
// Build option SPI_XFER_ARB_PRIORITY_EN: fixed-priority arbitration (lowest
// index wins) with no rotation pointer; otherwise round-robin.
module spi_xfer_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = spi_pkg::DEF_DATA_WIDTH,
    parameter int GAP_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wr_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic [NUM_REQ-1:0]            ss_sel,
    output logic                          eng_start,
    output logic [DATA_WIDTH-1:0]         eng_wr_data,
    input  logic                          eng_busy,
    input  logic                          eng_done,
    input  logic [DATA_WIDTH-1:0]         eng_rd_data
);
    import spi_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    logic [1:0]            state;
    logic [CNT_W-1:0]      gap_cnt;
    logic [PTR_W-1:0]      arb_ptr;
    logic [PTR_W-1:0]      arb_idx;
    logic [NUM_REQ-1:0]    arb_grant;
    logic                  arb_any;
    logic [DATA_WIDTH-1:0] words [NUM_REQ];

    // Split the flat requester data bus into one word per requester
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            words[i] = req_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    spi_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req       (req),
        .ptr       (arb_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

`ifdef SPI_XFER_ARB_PRIORITY_EN
    assign arb_ptr = '0;
`else
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] winner;

    assign arb_ptr = rr_ptr;

    // Remember the granted requester and advance the pointer past it when its
    // transfer completes, so a requester holding req waits its turn
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            winner <= '0;
        end else if (state == IDLE && arb_any) begin
            winner <= arb_idx;
        end else if (state == XFER && eng_done) begin
            rr_ptr <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
        end
    end
`endif

    // Transfer sequencer; reset aborts any transfer and drops the slave select
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            gap_cnt     <= '0;
            gnt         <= '0;
            done        <= '0;
            rd_data     <= '0;
            ss_sel      <= '0;
            eng_start   <= 1'b0;
            eng_wr_data <= '0;
        end else begin
            done      <= '0;
            eng_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        gnt         <= arb_grant;
                        ss_sel      <= arb_grant;
                        eng_wr_data <= words[arb_idx];
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    // Slave select has been up a full cycle; hold off while the
                    // engine still reports activity
                    if (!eng_busy) begin
                        eng_start <= 1'b1;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (eng_done) begin
                        rd_data <= eng_rd_data;
                        done    <= gnt;
                        gnt     <= '0;
                        ss_sel  <= '0;
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter with a behavioural SPI engine and a
// scoreboard of expected engine starts and completions.
module tb_spi_xfer_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DW      = 16;
    localparam int GAP     = 4;
    localparam int ENG_LAT = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*DW-1:0] req_wr_data;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    done;
    logic [DW-1:0]         rd_data;
    logic [NUM_REQ-1:0]    ss_sel;
    logic                  eng_start;
    logic [DW-1:0]         eng_wr_data;
    logic                  eng_busy = 1'b0;
    logic                  eng_done = 1'b0;
    logic [DW-1:0]         eng_rd_data = '0;

    int checks = 0;
    int failures = 0;
    int done_seen = 0;
    int start_seen = 0;
    int spur_req = 0;

    logic [NUM_REQ-1:0] exp_ss_q[$];
    logic [DW-1:0]      exp_wd_q[$];
    logic [NUM_REQ-1:0] exp_done_q[$];
    logic [DW-1:0]      exp_rd_q[$];
    logic [DW-1:0]      reply_q[$];

    always #5 clk = ~clk;

    spi_xfer_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DW),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_wr_data (req_wr_data),
        .gnt         (gnt),
        .done        (done),
        .rd_data     (rd_data),
        .ss_sel      (ss_sel),
        .eng_start   (eng_start),
        .eng_wr_data (eng_wr_data),
        .eng_busy    (eng_busy),
        .eng_done    (eng_done),
        .eng_rd_data (eng_rd_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push_xfer(input logic [NUM_REQ-1:0] ss, input logic [DW-1:0] wd,
                             input logic [DW-1:0] rd, input bit completes);
        exp_ss_q.push_back(ss);
        exp_wd_q.push_back(wd);
        reply_q.push_back(rd);
        if (completes) begin
            exp_done_q.push_back(ss);
            exp_rd_q.push_back(rd);
        end
    endtask

    task automatic wait_done(input int target, input int budget);
        int t = 0;
        while (done_seen < target && t < budget) begin
            @(posedge clk); #2;
            t++;
        end
        check("wait_done", 32'(done_seen >= target), 1);
    endtask

    // Behavioural engine: busy for ENG_LAT cycles after start, then a done pulse
    int busy_cnt = 0;
    int spur_seen = 0;
    logic [DW-1:0] cur_reply;
    always @(negedge clk) begin
        eng_done = 1'b0;
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                eng_busy    = 1'b0;
                eng_done    = 1'b1;
                eng_rd_data = cur_reply;
            end
        end else if (eng_start) begin
            eng_busy  = 1'b1;
            busy_cnt  = ENG_LAT;
            cur_reply = (reply_q.size() > 0) ? reply_q.pop_front() : 16'hDEAD;
        end else if (spur_req != spur_seen) begin
            spur_seen   = spur_req;
            eng_done    = 1'b1;
            eng_rd_data = 16'hBEEF;
        end
    end

    // Scoreboard monitor, sampled just after each rising edge
    int zero_run = 0;
    bit had_xfer = 0;
    always @(posedge clk) begin
        #1;
        if (eng_start === 1'b1) begin
            start_seen++;
            if (exp_ss_q.size() == 0) begin
                check("unexpected_start", {28'd0, ss_sel}, 0);
            end else begin
                check("start_ss_sel", {28'd0, ss_sel}, {28'd0, exp_ss_q.pop_front()});
                check("start_wr_data", {16'd0, eng_wr_data}, {16'd0, exp_wd_q.pop_front()});
                check("start_gnt_eq_ss", {28'd0, gnt}, {28'd0, ss_sel});
                check("start_while_busy", {31'd0, eng_busy}, 0);
            end
        end
        if (done !== '0) begin
            done_seen++;
            if (exp_done_q.size() == 0) begin
                check("unexpected_done", {28'd0, done}, 0);
            end else begin
                check("done_vec", {28'd0, done}, {28'd0, exp_done_q.pop_front()});
                check("rd_data", {16'd0, rd_data}, {16'd0, exp_rd_q.pop_front()});
                check("done_latency", {31'd0, eng_done}, 1);
            end
        end
        if (ss_sel === '0) begin
            zero_run++;
        end else begin
            if (had_xfer && zero_run > 0) check("gap_len", 32'(zero_run >= GAP), 1);
            zero_run = 0;
            had_xfer = 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1;
        req = '0;
        req_wr_data = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", {28'd0, gnt}, 0);
        check("rst_done", {28'd0, done}, 0);
        check("rst_rd_data", {16'd0, rd_data}, 0);
        check("rst_ss_sel", {28'd0, ss_sel}, 0);
        check("rst_eng_start", {31'd0, eng_start}, 0);
        check("rst_eng_wr_data", {16'd0, eng_wr_data}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single transfer from requester 1 with latency checks
        req_wr_data[1*DW +: DW] = 16'h0074;
        push_xfer(4'b0010, 16'h0074, 16'h0035, 1);
        req = 4'b0010;
        @(posedge clk); #1;
        check("lat_no_start_yet", {31'd0, eng_start}, 0);
        check("lat_gnt", {28'd0, gnt}, 4'b0010);
        check("lat_ss_sel", {28'd0, ss_sel}, 4'b0010);
        @(posedge clk); #1;
        check("lat_start", {31'd0, eng_start}, 1);
        wait_done(1, 50);
        req = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rd_hold", {16'd0, rd_data}, 16'h0035);

        // Spurious engine done while idle
        repeat (4) @(posedge clk);
        spur_req++;
        repeat (4) @(posedge clk);
        #1;
        check("spur_rd_data", {16'd0, rd_data}, 16'h0035);
        check("spur_no_done", done_seen, 1);
        check("spur_no_start", start_seen, 1);

        // Reset in the middle of a transfer from requester 2
        req_wr_data[2*DW +: DW] = 16'h1234;
        push_xfer(4'b0100, 16'h1234, 16'h7777, 0);
        req = 4'b0100;
        begin
            int t = 0;
            while (eng_busy !== 1'b1 && t < 20) begin
                @(posedge clk); #1;
                t++;
            end
        end
        check("abort_engine_busy", {31'd0, eng_busy}, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_gnt", {28'd0, gnt}, 0);
        check("abort_ss_sel", {28'd0, ss_sel}, 0);
        check("abort_eng_start", {31'd0, eng_start}, 0);
        check("abort_rd_data", {16'd0, rd_data}, 0);
        check("abort_eng_wr_data", {16'd0, eng_wr_data}, 0);
        rst = 1'b0;
        req = '0;
        repeat (6) @(posedge clk);
        #1;
        check("abort_late_done_ignored", done_seen, 1);
        check("abort_rd_after", {16'd0, rd_data}, 0);

        for (int i = 0; i < NUM_REQ; i++) req_wr_data[i*DW +: DW] = 16'hA000 + 16'(i);

`ifdef SPI_XFER_ARB_PRIORITY_EN
        // Fixed priority: requester 1 keeps winning over 3
        base = done_seen;
        for (int k = 0; k < 3; k++) push_xfer(4'b0010, 16'hA001, 16'hD000 + 16'(k), 1);
        req = 4'b1010;
        wait_done(base + 3, 200);
        req = '0;
`else
        // All requesters held: grants rotate 0,1,2,3,0,1,2,3
        base = done_seen;
        for (int k = 0; k < 8; k++) begin
            push_xfer(4'(1 << (k % 4)), 16'hA000 + 16'(k % 4), 16'hC000 + 16'(k), 1);
        end
        req = 4'b1111;
        wait_done(base + 8, 400);
        req = '0;
        check("rot_all_started", exp_ss_q.size(), 0);
`endif

        // Request from 2 arriving during the gap of a transfer from 0
        repeat (8) @(posedge clk);
        base = done_seen;
        push_xfer(4'b0001, 16'hA000, 16'hE001, 1);
        push_xfer(4'b0100, 16'hA002, 16'hE002, 1);
        req = 4'b0001;
        wait_done(base + 1, 50);
        req = 4'b0100;
        for (int k = 0; k < GAP; k++) begin
            @(posedge clk); #1;
            check("gap_no_start", {31'd0, eng_start}, 0);
            check("gap_ss_low", {28'd0, ss_sel}, 0);
        end
        wait_done(base + 2, 50);
        req = '0;

        repeat (10) @(posedge clk);
        #1;
        check("final_done_q_empty", exp_done_q.size(), 0);
        check("final_start_q_empty", exp_ss_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_xfer_arbiter.md
Name: spi_xfer_arbiter

Overview:
- Shares one SPI master shift engine among NUM_REQ requesters using round-robin arbitration.
- Sequences each transfer: grant, select target slave, start engine, wait for completion, return read data, enforce inter-transfer gap.
- Sits between register/DMA clients and the SPI shift engine (same mode as spi_master_bfm, CPOL/CPHA owned by the engine).

Parameters:
- NUM_REQ, 4, number of requesters and slave-select lines (2..8).
- DATA_WIDTH, 16, transfer word width.
- GAP_CYCLES, 4, clk cycles with no slave selected between back-to-back transfers (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester transfer request, level, held until done.
- req_wr_data  in  NUM_REQ*DATA_WIDTH  requester i word at bits [i*DATA_WIDTH +: DATA_WIDTH].
- gnt  out  NUM_REQ  one-hot grant, high from grant through done.
- done  out  NUM_REQ  one-cycle pulse to owning requester at completion.
- rd_data  out  DATA_WIDTH  word read from slave, valid in the done cycle, held until next done.
- ss_sel  out  NUM_REQ  one-hot slave select to engine/pads, active-high.
- eng_start  out  1  one-cycle start pulse to engine.
- eng_wr_data  out  DATA_WIDTH  word to shift out, stable from eng_start until eng_done.
- eng_busy  in  1  engine shifting.
- eng_done  in  1  one-cycle pulse, engine finished.
- eng_rd_data  in  DATA_WIDTH  captured word, valid with eng_done.

Behaviour:
- Reset: gnt=0, done=0, rd_data=0, ss_sel=0, eng_start=0, eng_wr_data=0, state=IDLE, rr pointer=0. Reset mid-transfer aborts immediately; ss_sel drops next edge; a late eng_done is ignored.
- IDLE: if any req, pick first set bit searching from rr pointer upward with wrap; register winner; gnt, ss_sel set; latch eng_wr_data -> SETUP. Decision is one cycle after req is seen.
- SETUP: one cycle, ss asserted before clocking; eng_start=1 -> XFER.
- XFER: wait for eng_done; on eng_done capture eng_rd_data into rd_data, pulse done[winner], clear gnt and ss_sel -> GAP; rr pointer = winner+1 mod NUM_REQ.
- GAP: count GAP_CYCLES cycles, then -> IDLE. Requests asserted during GAP wait.
- Latency: req rise in IDLE to eng_start = 2 cycles; eng_done to done = 1 cycle.
- Requester dropping req after grant: transfer still completes; done still pulses.
- eng_done in any state other than XFER is ignored. eng_busy is informational; eng_start is never issued while eng_busy=1; if it is high in SETUP, the block stalls in SETUP.
- All requests asserted continuously: grants rotate 0,1,2,3,0...
- A requester holding req after its done is re-eligible only after rr has passed it.

Optional Feature:
- SPI_XFER_ARB_PRIORITY_EN: when defined, arbitration is fixed priority, lowest index wins, and the rr pointer is removed. Undefined: round-robin as above.

Decomposition:
- Package spi_pkg: state enum (IDLE, SETUP, XFER, GAP), default DATA_WIDTH constant, function for first-set-bit-from-pointer search.
- Sub-module spi_rr_arbiter: combinational request vector plus pointer in, one-hot grant out. It holds the priority-macro variant.

Test Plan:
- Single: req=4'b0010, req_wr_data[1]=16'h0074, engine model returns 16'h0035 -> ss_sel=4'b0010, eng_wr_data=16'h0074, done[1] pulse, rd_data=16'h0035.
- All req=4'b1111 held for 8 transfers -> grant order 0,1,2,3,0,1,2,3; at least GAP_CYCLES cycles with ss_sel=0 between transfers.
- req[2] asserted during GAP of transfer 0 -> no eng_start until GAP ends; then granted 2.
- rst pulsed mid-XFER -> all outputs 0 next cycle; subsequent eng_done gives no done pulse; next request served normally.
- Spurious eng_done in IDLE -> no done, rd_data unchanged.
- With SPI_XFER_ARB_PRIORITY_EN, req=4'b1010 held -> requester 1 granted repeatedly; requester 3 never granted while req[1] stays high.
